// File: rtl/spi_controller.sv
// SPI mode-0 initiator: byte handshake in, CS held across multi-byte commands.
// Define SPI_CONTROLLER_LOOPBACK_EN to capture the internal copi instead of cipo.
module spi_controller #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_spi_clk,
  output logic       o_spi_copi,
  input  logic       i_spi_cipo,
  output logic       o_spi_cs_n
);

  localparam int HW = (CLKS_PER_HALF_BIT > 1) ?
                      $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int GW = (CS_INACTIVE_CLKS > 1) ?
                      $clog2(CS_INACTIVE_CLKS) : 1;
  localparam logic [HW-1:0] HRLD = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [GW-1:0] GRLD = GW'(CS_INACTIVE_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_HOLD, S_REL, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          last_q, last_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          csn_q, csn_d;
  logic          rdy_q, rdy_d;
  logic          rxdv_q, rxdv_d;
  logic [7:0]    rxb_q, rxb_d;
  logic          accept, hzero, rx_in;

`ifdef SPI_CONTROLLER_LOOPBACK_EN
  logic unused_cipo;
  assign unused_cipo = i_spi_cipo;
  assign rx_in = copi_q;
`else
  assign rx_in = i_spi_cipo;
`endif

  assign accept = i_tx_dv && rdy_q;
  assign hzero  = (hcnt_q == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (hzero && sclk_q && bit_q == 3'd7)
                 state_d = last_q ? S_REL : S_HOLD;
      S_HOLD:  if (accept) state_d = S_SHIFT;
      S_REL:   if (hzero) state_d = S_GAP;
      S_GAP:   if (gcnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hcnt_d = hcnt_q;
    gcnt_d = gcnt_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    last_d = last_q;
    sclk_d = sclk_q;
    copi_d = copi_q;
    csn_d  = csn_q;
    rxdv_d = 1'b0;
    rxb_d  = rxb_q;
    if (accept) begin
      tx_d   = i_tx_byte;
      last_d = i_tx_last;
      copi_d = i_tx_byte[7];
      csn_d  = 1'b0;
      hcnt_d = HRLD;
      bit_d  = 3'd0;
      sclk_d = 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (hzero) begin
            hcnt_d = HRLD;
            sclk_d = !sclk_q;
            if (!sclk_q) begin
              rx_d = {rx_q[6:0], rx_in};
            end else begin
              bit_d = bit_q + 3'd1;
              // 8th fall ends the byte; copi keeps bit0
              if (bit_q == 3'd7) begin
                rxdv_d = 1'b1;
                rxb_d  = rx_q;
              end else begin
                tx_d   = {tx_q[6:0], 1'b0};
                copi_d = tx_q[6];
              end
            end
          end else begin
            hcnt_d = hcnt_q - HW'(1);
          end
        end
        S_REL: begin
          if (hzero) begin
            csn_d  = 1'b1;
            gcnt_d = GRLD;
          end else begin
            hcnt_d = hcnt_q - HW'(1);
          end
        end
        S_GAP: if (gcnt_q != '0) gcnt_d = gcnt_q - GW'(1);
        default: ;
      endcase
    end
  end

  // HOLD raises ready one cycle after the byte-end strobe
  assign rdy_d = !accept &&
                 (state_d == S_IDLE || state_q == S_HOLD);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hcnt_q <= '0;
      gcnt_q <= '0;
      bit_q  <= 3'd0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
      last_q <= 1'b0;
      sclk_q <= 1'b0;
      copi_q <= 1'b0;
      csn_q  <= 1'b1;
      rdy_q  <= 1'b1;
      rxdv_q <= 1'b0;
      rxb_q  <= 8'h00;
    end else begin
      hcnt_q <= hcnt_d;
      gcnt_q <= gcnt_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      last_q <= last_d;
      sclk_q <= sclk_d;
      copi_q <= copi_d;
      csn_q  <= csn_d;
      rdy_q  <= rdy_d;
      rxdv_q <= rxdv_d;
      rxb_q  <= rxb_d;
    end
  end

  assign o_tx_ready = rdy_q;
  assign o_rx_dv    = rxdv_q;
  assign o_rx_byte  = rxb_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_copi = copi_q;
  assign o_spi_cs_n = csn_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: peripheral model, rx monitor,
// directed scenarios plus random multi-byte commands.
module tb_spi_controller;
  localparam int NA = 2;
  localparam int GA = 4;
`ifdef SPI_CONTROLLER_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct {
    logic [7:0] rx;
    int         acc;
  } exp_t;

  logic clk, rst_n;
  logic dv, last, cipo;
  logic [7:0] txb;
  logic rdy, rxdv, sclk, copi, csn;
  logic [7:0] rxb;

  logic dv1, last1;
  logic [7:0] txb1;
  logic rdy1, rxdv1, sclk1, copi1, csn1;
  logic [7:0] rxb1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int rises = 0;
  int n_rx = 0;
  int n_csn_rise = 0;
  int n_csn_fall = 0;
  int csn_rise_cyc = -1;
  int rdy_rise_cyc = -1;

  exp_t       exp_q[$];
  logic [7:0] wire_q[$];
  logic [7:0] resp_q[$];

  spi_controller #(.CLKS_PER_HALF_BIT(NA), .CS_INACTIVE_CLKS(GA)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_tx_dv(dv), .i_tx_byte(txb),
    .i_tx_last(last), .o_tx_ready(rdy), .o_rx_dv(rxdv),
    .o_rx_byte(rxb), .o_spi_clk(sclk), .o_spi_copi(copi),
    .i_spi_cipo(cipo), .o_spi_cs_n(csn));

  spi_controller #(.CLKS_PER_HALF_BIT(1), .CS_INACTIVE_CLKS(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_tx_dv(dv1), .i_tx_byte(txb1),
    .i_tx_last(last1), .o_tx_ready(rdy1), .o_rx_dv(rxdv1),
    .o_rx_byte(rxb1), .o_spi_clk(sclk1), .o_spi_copi(copi1),
    .i_spi_cipo(1'b1), .o_spi_cs_n(csn1));

  function automatic void chk(input string nm, input int act,
                              input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // rx monitor: every strobe must match the oldest expectation
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rxdv) begin
      n_rx++;
      chk("rx_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rx_byte", rxb, e.rx);
        chk("rx_latency", cyc - e.acc, 1 + 16 * NA);
      end
    end
  end

  // cs_n / ready edge tracker
  initial begin
    logic pcsn, prdy;
    pcsn = 1'b1;
    prdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (csn && !pcsn) begin
        n_csn_rise++;
        csn_rise_cyc = cyc;
      end
      if (!csn && pcsn) n_csn_fall++;
      if (rdy && !prdy) rdy_rise_cyc = cyc;
      pcsn = csn;
      prdy = rdy;
    end
  end

  // mode-0 peripheral: drives cipo MSB first, captures copi on rises
  initial begin
    logic pclk, need;
    logic [7:0] cur, sh;
    int nr, nf;
    pclk = 1'b0; need = 1'b1; cur = 8'h00; sh = 8'h00;
    nr = 0; nf = 0; cipo = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || csn) begin
        need = 1'b1; nr = 0; nf = 0; cipo = 1'b0;
      end else begin
        if (sclk && !pclk) begin
          rises++;
          sh = {sh[6:0], copi};
          nr++;
          if (nr == 8) begin
            nr = 0;
            chk("wire_expected", int'(wire_q.size() > 0), 1);
            if (wire_q.size() > 0) chk("copi_byte", sh, wire_q.pop_front());
          end
        end
        if (!sclk && pclk) begin
          nf++;
          if (nf == 8) begin
            nf = 0;
            need = 1'b1;
          end else begin
            cipo = cur[7 - nf];
          end
        end
        if (need && resp_q.size() > 0) begin
          cur = resp_q.pop_front();
          need = 1'b0;
          cipo = cur[7];
        end
      end
      pclk = sclk;
    end
  end

  task automatic send(input logic [7:0] b, input logic l,
                      input logic [7:0] r);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("tx_ready_wait", int'(rdy), 1);
    dv = 1'b1; txb = b; last = l;
    last_acc = cyc;
    resp_q.push_back(r);
    wire_q.push_back(b);
    e.rx = LOOP ? b : r;
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (rdy_rise_cyc <= last_acc && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("idle_timeout", int'(rdy_rise_cyc > last_acc), 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, rdy, 1);
    chk({tag, "_rx_dv"}, rxdv, 0);
    chk({tag, "_rx_byte"}, rxb, 0);
    chk({tag, "_spi_clk"}, sclk, 0);
    chk({tag, "_copi"}, copi, 0);
    chk({tag, "_cs_n"}, csn, 1);
  endtask

  initial begin
    int r0, x0, f0, c0, t, a, r1, r2, rxc, csr, rdr;
    logic [7:0] rx1;
    logic p1clk, p1csn, p1rdy;
    rst_n = 1'b0; dv = 1'b0; txb = 8'h00; last = 1'b0;
    dv1 = 1'b0; txb1 = 8'h00; last1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single byte 0xA5, peripheral answers 0x3C
    send(8'hA5, 1'b1, 8'h3C);
    chk("cyc1_cs_n", csn, 0);
    chk("cyc1_copi_bit7", copi, 1);
    wait_idle();
    chk("cs_release_cycle", csn_rise_cyc - last_acc, 1 + 17 * NA);
    chk("ready_after_gap", rdy_rise_cyc - last_acc, 1 + 17 * NA + GA);

    // three-byte command, cs held low throughout
    r0 = rises; x0 = n_rx; f0 = n_csn_fall; c0 = n_csn_rise;
    send(8'h01, 1'b0, 8'($urandom));
    send(8'h00, 1'b0, 8'($urandom));
    send(8'h10, 1'b1, 8'($urandom));
    wait_idle();
    chk("cmd3_rises", rises - r0, 24);
    chk("cmd3_rx_pulses", n_rx - x0, 3);
    chk("cmd3_cs_falls", n_csn_fall - f0, 1);
    chk("cmd3_cs_rises", n_csn_rise - c0, 1);

    // offered byte while busy must be dropped
    r0 = rises; x0 = n_rx;
    send(8'hAA, 1'b0, 8'($urandom));
    repeat (5) @(negedge clk);
    dv = 1'b1; txb = 8'hFF; last = 1'b1;
    repeat (6) @(negedge clk);
    dv = 1'b0;
    send(8'h42, 1'b1, 8'($urandom));
    wait_idle();
    chk("busy_rises", rises - r0, 16);
    chk("busy_rx_pulses", n_rx - x0, 2);

    // N=1, gap=1 instance
    @(negedge clk);
    dv1 = 1'b1; txb1 = 8'h81; last1 = 1'b1;
    a = cyc;
    p1clk = sclk1; p1csn = csn1; p1rdy = rdy1;
    r1 = -1; r2 = -1; rxc = -1; csr = -1; rdr = -1; rx1 = 8'h00;
    @(posedge clk);
    #1;
    dv1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sclk1 && !p1clk) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      if (rxdv1) begin
        rxc = cyc;
        rx1 = rxb1;
      end
      if (csn1 && !p1csn) csr = cyc;
      if (rdy1 && !p1rdy) rdr = cyc;
      p1clk = sclk1; p1csn = csn1; p1rdy = rdy1;
      @(posedge clk);
      #1;
    end
    chk("n1_clk_period", r2 - r1, 2);
    chk("n1_rx_cycle", rxc - a, 17);
    chk("n1_rx_byte", rx1, LOOP ? 8'h81 : 8'hFF);
    chk("n1_cs_release", csr - a, 18);
    chk("n1_cs_high_cycles", rdr - csr, 1);

    // asynchronous reset after three rising edges
    r0 = rises;
    send(8'h5B, 1'b1, 8'($urandom));
    t = 0;
    while (rises < r0 + 3 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("reset_wait_rises", int'(rises >= r0 + 3), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    exp_q.delete();
    wire_q.delete();
    resp_q.delete();
    x0 = n_rx;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h5A, 1'b1, 8'($urandom));
    wait_idle();
    chk("after_reset_rx_pulses", n_rx - x0, 1);

    // loopback-sensitive byte
    send(8'hC3, 1'b1, 8'h00);
    wait_idle();

    // random commands of 1..4 bytes
    c0 = n_csn_rise;
    for (int k = 0; k < 15; k++) begin
      int len;
      len = int'($urandom_range(1, 4));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      for (int i = 0; i < len; i++)
        send(8'($urandom), i == len - 1, 8'($urandom));
    end
    wait_idle();
    chk("rand_cs_releases", n_csn_rise - c0, 15);
    repeat (5) @(posedge clk);
    chk("rx_queue_drained", exp_q.size(), 0);
    chk("wire_queue_drained", wire_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
